// File: rtl/ripple_mon_pkg.sv
// rtl/ripple_mon_pkg.sv - shared types and constants for the ripple counter monitor
package ripple_mon_pkg;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        TRACK = 2'd1,
        ERROR = 2'd2
    } mon_state_t;

    localparam int WIDTH_DEFAULT = 4;
    localparam int WRAP_CNT_W    = 8;

endpackage

// File: rtl/sync_stable_filter.sv
// rtl/sync_stable_filter.sv - two-flop synchronizer plus run-length filter that strobes settled values
module sync_stable_filter
    import ripple_mon_pkg::*;
#(
    parameter int WIDTH         = WIDTH_DEFAULT,
    parameter int STABLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] cnt_in,
    input  logic [WIDTH-1:0] cur,
    input  logic             track_init,
    output logic             acc,
    output logic [WIDTH-1:0] acc_val
);

    localparam int RUN_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYCLES);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] cand;
    logic [RUN_W-1:0] run;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1   <= '0;
            s2   <= '0;
            cand <= '0;
            run  <= '0;
        end else begin
            s1 <= cnt_in;
            s2 <= s1;
            if (s2 != cand) begin
                cand <= s2;
                run  <= RUN_W'(1);
            end else if (run != RUN_MAX) begin
                run <= run + RUN_W'(1);
            end
        end
    end

    // A return to the value already published is not an event, except right after reset.
    generate
        if (STABLE_CYCLES == 1) begin : g_single
            assign acc     = (s2 != cand) && (track_init || (s2 != cur));
            assign acc_val = s2;
        end else begin : g_multi
            assign acc     = (s2 == cand) && (run == RUN_W'(STABLE_CYCLES - 1))
                             && (track_init || (cand != cur));
            assign acc_val = cand;
        end
    endgenerate

endmodule

// File: rtl/ripple_count_monitor.sv
// rtl/ripple_count_monitor.sv - publishes settled ripple counter values and classifies each transition
module ripple_count_monitor
    import ripple_mon_pkg::*;
#(
    parameter int WIDTH         = WIDTH_DEFAULT,
    parameter int STABLE_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WIDTH-1:0]      cnt_in,
    input  logic                  up,
    input  logic                  clr_err,
    output logic [WIDTH-1:0]      cnt_out,
    output logic                  cnt_valid,
    output logic                  step_up,
    output logic                  step_dn,
    output logic                  wrap,
    output logic                  dir_err,
    output logic                  skip_err,
    output logic [WRAP_CNT_W-1:0] wrap_count
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] MAX = '1;

    mon_state_t            state;
    mon_state_t            state_nx;
    logic                  acc;
    logic [WIDTH-1:0]      acc_val;
    logic [WIDTH-1:0]      delta;
    logic                  skip_nx;
    logic                  su_nx;
    logic                  sd_nx;
    logic                  wr_nx;
    logic                  de_nx;
    logic [WRAP_CNT_W-1:0] wc_nx;

    sync_stable_filter #(
        .WIDTH         (WIDTH),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .clk        (clk),
        .rst_n      (rst_n),
        .cnt_in     (cnt_in),
        .cur        (cnt_out),
        .track_init (state == INIT),
        .acc        (acc),
        .acc_val    (acc_val)
    );

    assign delta = acc_val - cnt_out;

    always_comb begin
        state_nx = state;
        skip_nx  = skip_err;
        su_nx    = 1'b0;
        sd_nx    = 1'b0;
        wr_nx    = 1'b0;
        de_nx    = 1'b0;
        wc_nx    = wrap_count;
        case (state)
            INIT: begin
                if (acc) state_nx = TRACK;
            end
            TRACK: begin
                if (acc) begin
                    if (delta == ONE) begin
                        su_nx = 1'b1;
                        de_nx = !up;
                        wr_nx = (cnt_out == MAX);
                    end else if (delta == MAX) begin
                        sd_nx = 1'b1;
                        de_nx = up;
                        wr_nx = (cnt_out == '0);
                    end else begin
                        skip_nx  = 1'b1;
                        state_nx = ERROR;
                    end
                end
            end
            ERROR: begin
                // Acceptances here only republish the value; the clear wins over any new skip.
                if (clr_err) begin
                    skip_nx  = 1'b0;
                    state_nx = TRACK;
                end
            end
            default: state_nx = INIT;
        endcase
        if (wr_nx && (wrap_count != '1)) wc_nx = wrap_count + WRAP_CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= INIT;
            cnt_out    <= '0;
            cnt_valid  <= 1'b0;
            step_up    <= 1'b0;
            step_dn    <= 1'b0;
            wrap       <= 1'b0;
            dir_err    <= 1'b0;
            skip_err   <= 1'b0;
            wrap_count <= '0;
        end else begin
            state      <= state_nx;
            cnt_valid  <= acc;
            step_up    <= su_nx;
            step_dn    <= sd_nx;
            wrap       <= wr_nx;
            dir_err    <= de_nx;
            skip_err   <= skip_nx;
            wrap_count <= wc_nx;
            if (acc) cnt_out <= acc_val;
        end
    end

endmodule

// File: tb/tb_ripple_count_monitor.sv
// tb/tb_ripple_count_monitor.sv - directed and randomized self-checking bench for ripple_count_monitor
module tb_ripple_count_monitor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] cnt_in;
    logic       up;
    logic       clr_err;
    logic [3:0] cnt_out;
    logic       cnt_valid;
    logic       step_up;
    logic       step_dn;
    logic       wrap;
    logic       dir_err;
    logic       skip_err;
    logic [7:0] wrap_count;

    always #5 clk = ~clk;

    ripple_count_monitor #(.WIDTH(4), .STABLE_CYCLES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cnt_in     (cnt_in),
        .up         (up),
        .clr_err    (clr_err),
        .cnt_out    (cnt_out),
        .cnt_valid  (cnt_valid),
        .step_up    (step_up),
        .step_dn    (step_dn),
        .wrap       (wrap),
        .dir_err    (dir_err),
        .skip_err   (skip_err),
        .wrap_count (wrap_count)
    );

    typedef struct packed {
        logic [3:0] cnt;
        logic       su;
        logic       sd;
        logic       wr;
        logic       de;
        logic       sk;
        logic [7:0] wc;
    } ev_t;

    ev_t obs_q[$];
    ev_t exp_q[$];
    int  total = 0;
    int  bad   = 0;
    int  n_valid = 0, n_su = 0, n_sd = 0, n_wr = 0, n_de = 0, stray = 0;
    int  s_valid, s_su, s_sd, s_wr, s_de;
    logic prev_valid = 1'b0;

    // Monitor: every acceptance is logged; flags without cnt_valid or stretched pulses are strays.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (cnt_valid === 1'b1) begin
                obs_q.push_back({cnt_out, step_up, step_dn, wrap, dir_err, skip_err, wrap_count});
                n_valid++;
                n_su += int'(step_up);
                n_sd += int'(step_dn);
                n_wr += int'(wrap);
                n_de += int'(dir_err);
                if (prev_valid) stray++;
            end else if (step_up | step_dn | wrap | dir_err) begin
                stray++;
            end
        end
        prev_valid = (cnt_valid === 1'b1);
    end

    // Reference model: runs of equal input samples; a run of 2+ samples that differs from the
    // published value (or the first run after reset) is one acceptance.
    int         m_mode;
    logic [3:0] m_cnt;
    int         m_wc;
    logic       m_sk;
    logic [3:0] run_v;
    int         run_len;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic m_reset();
        m_mode  = 0;
        m_cnt   = 4'd0;
        m_wc    = 0;
        m_sk    = 1'b0;
        run_v   = 4'd0;
        run_len = 2;
    endtask

    task automatic m_accept(input logic [3:0] v);
        ev_t        e;
        logic [3:0] d;
        d = v - m_cnt;
        e = '0;
        e.cnt = v;
        if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (d == 4'd1) begin
                e.su = 1'b1;
                e.de = !up;
                if (v == 4'd0) begin
                    e.wr = 1'b1;
                    if (m_wc < 255) m_wc++;
                end
            end else if (d == 4'd15) begin
                e.sd = 1'b1;
                e.de = up;
                if (v == 4'd15) begin
                    e.wr = 1'b1;
                    if (m_wc < 255) m_wc++;
                end
            end else begin
                m_sk   = 1'b1;
                m_mode = 2;
            end
        end
        m_cnt = v;
        e.sk  = m_sk;
        e.wc  = 8'(m_wc);
        exp_q.push_back(e);
    endtask

    task automatic finalize();
        if (run_len >= 2 && (m_mode == 0 || run_v != m_cnt)) m_accept(run_v);
    endtask

    task automatic seg(input logic [3:0] v, input int h);
        if (v == run_v) begin
            run_len += h;
        end else begin
            finalize();
            run_v   = v;
            run_len = h;
        end
        cnt_in = v;
        repeat (h) step();
    endtask

    task automatic settle();
        run_len += 6;
        repeat (6) step();
        finalize();
        run_len = 0;
    endtask

    task automatic clr();
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        if (m_mode == 2) begin
            m_mode = 1;
            m_sk   = 1'b0;
        end
    endtask

    task automatic drain(input string tag);
        ev_t o, e;
        chk({tag, "_events"}, obs_q.size(), exp_q.size());
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            chk({tag, "_event"}, 32'(o), 32'(e));
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic snap();
        s_valid = n_valid;
        s_su    = n_su;
        s_sd    = n_sd;
        s_wr    = n_wr;
        s_de    = n_de;
    endtask

    task automatic do_reset();
        drain("pre_reset");
        cnt_in = 4'd0;
        rst_n  = 1'b0;
        step();
        rst_n  = 1'b1;
        m_reset();
    endtask

    initial begin
        logic [3:0] cur;
        logic [3:0] v;
        int         seen;
        int         r;

        rst_n   = 1'b0;
        cnt_in  = 4'd0;
        up      = 1'b1;
        clr_err = 1'b0;
        repeat (3) step();
        chk("rst_cnt_out", cnt_out, 0);
        chk("rst_flags", {cnt_valid, step_up, step_dn, wrap, dir_err, skip_err}, 0);
        chk("rst_wrap_count", wrap_count, 0);
        rst_n = 1'b1;
        m_reset();

        snap();
        settle();
        drain("init");
        chk("init_one_valid", n_valid - s_valid, 1);
        chk("init_cnt_out", cnt_out, 0);

        // Clean change latency, then the rest of a full upward lap.
        snap();
        cnt_in = 4'd1;
        run_v  = 4'd1;
        run_len = 4;
        finalize();
        seen = 0;
        for (int k = 1; k <= 4; k++) begin
            step();
            if (cnt_valid === 1'b1 && seen == 0) seen = k;
        end
        chk("latency_edges", seen, 4);
        for (int i = 2; i <= 16; i++) seg(4'(i), 4);
        settle();
        drain("up_lap");
        chk("up_lap_step_up", n_su - s_su, 16);
        chk("up_lap_wrap", n_wr - s_wr, 1);
        chk("up_lap_dir_err", n_de - s_de, 0);
        chk("up_lap_wrap_count", wrap_count, 1);

        up = 1'b0;
        do_reset();
        settle();
        snap();
        seg(4'd15, 4);
        seg(4'd14, 4);
        settle();
        drain("down");
        chk("down_step_dn", n_sd - s_sd, 2);
        chk("down_wrap", n_wr - s_wr, 1);
        chk("down_wrap_count", wrap_count, 1);

        up = 1'b1;
        seg(4'd15, 4);
        seg(4'd0, 4);
        seg(4'd1, 4);
        seg(4'd2, 4);
        settle();
        drain("to_two");

        seg(4'd5, 4);
        settle();
        drain("skip");
        chk("skip_sticky", skip_err, 1);
        snap();
        seg(4'd6, 4);
        settle();
        drain("in_error");
        chk("error_no_step", n_su - s_su, 0);
        chk("error_cnt_out", cnt_out, 6);
        clr();
        chk("clr_skip_err", skip_err, 0);
        snap();
        seg(4'd7, 4);
        settle();
        drain("after_clr");
        chk("after_clr_step_up", n_su - s_su, 1);

        snap();
        seg(4'd6, 1);
        seg(4'd4, 1);
        seg(4'd0, 1);
        seg(4'd8, 4);
        settle();
        drain("ripple");
        chk("ripple_one_valid", n_valid - s_valid, 1);
        chk("ripple_cnt_out", cnt_out, 8);
        chk("ripple_step_up", n_su - s_su, 1);
        chk("ripple_skip_err", skip_err, 0);

        seg(4'd9, 4);
        settle();
        snap();
        seg(4'd8, 4);
        settle();
        drain("dir");
        chk("dir_step_dn", n_sd - s_sd, 1);
        chk("dir_dir_err", n_de - s_de, 1);

        seg(4'd15, 4);
        settle();
        clr();
        seg(4'd0, 4);
        settle();
        drain("third_wrap");
        chk("pre_reset_wrap_count", wrap_count, 3);

        drain("mid_reset");
        rst_n = 1'b0;
        step();
        chk("mid_reset_wrap_count", wrap_count, 0);
        chk("mid_reset_cnt_out", cnt_out, 0);
        chk("mid_reset_skip_err", skip_err, 0);
        rst_n = 1'b1;
        m_reset();
        settle();
        drain("post_reset");

        // Randomized walks: mostly steps, some jumps and single-cycle ripple glitches.
        cur = 4'd0;
        for (int blk = 0; blk < 2; blk++) begin
            up = (blk == 0);
            for (int n = 0; n < 60; n++) begin
                r = int'($urandom_range(0, 7));
                if (r < 5) begin
                    v = (($urandom_range(0, 3) != 0) == up) ? cur + 4'd1 : cur - 4'd1;
                    cur = v;
                    seg(v, int'($urandom_range(2, 5)));
                end else if (r == 5) begin
                    v = 4'($urandom_range(0, 15));
                    cur = v;
                    seg(v, int'($urandom_range(2, 5)));
                end else begin
                    seg(4'($urandom_range(0, 15)), 1);
                    seg(cur, int'($urandom_range(2, 4)));
                end
            end
            settle();
            drain("random");
            clr();
        end

        chk("stray_pulses", stray, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ripple_count_monitor.md
Name: ripple_count_monitor

Overview:
- Downstream consumer of the 4-bit up/down ripple counter's q output.
- The ripple counter's bits settle at different times, so q shows transient codes during each transition.
- This block brings q into the system clock domain and filters out the transients. It publishes each settled count and classifies each transition as up-step, down-step, wrap or illegal skip.
- Its flags feed status logic and the bench scoreboard.

Parameters:
- WIDTH, 4: width of the monitored count.
- STABLE_CYCLES, 2: number of consecutive equal synchronized samples needed to accept a value (≥1).

Ports:
- clk  input  1  system clock; must be faster than the counter's update rate.
- rst_n  input  1  synchronous active-low reset.
- cnt_in  input  WIDTH  raw q from the ripple counter; asynchronous to clk.
- up  input  1  expected count direction (1 = up, 0 = down).
- clr_err  input  1  one-cycle pulse; clears the sticky error and resumes tracking.
- cnt_out  output  WIDTH  last accepted (settled) count.
- cnt_valid  output  1  one-cycle pulse on every acceptance.
- step_up  output  1  pulse: accepted value = previous + 1 (mod 2^WIDTH).
- step_dn  output  1  pulse: accepted value = previous − 1 (mod 2^WIDTH).
- wrap  output  1  pulse: max→0 or 0→max transition.
- dir_err  output  1  pulse: step_up while up=0, or step_dn while up=1.
- skip_err  output  1  sticky: accepted delta was neither +1 nor −1.
- wrap_count  output  8  count of wrap events; saturates at 255.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n, sampled on the rising edge of clk.
- Reset values:
  - cnt_out=0 and wrap_count=0.
  - All pulse outputs = 0; skip_err=0.
  - Synchronizer flops s1/s2 = 0; candidate cand=0; run=0.
  - FSM = INIT.
- Synchronizer: s1<=cnt_in, s2<=s1. No other logic reads cnt_in.
- Stability filter, evaluated each edge:
  - If s2≠cand: cand<=s2, run<=1.
  - Else run<=min(run+1, STABLE_CYCLES).
  - Acceptance occurs on the edge where s2==cand and run==STABLE_CYCLES−1. It also requires (state==INIT or cand≠cnt_out).
  - For STABLE_CYCLES=1, acceptance occurs on the edge where s2 first differs from cand (cand≠cnt_out).
- Latency: after a clean change of cnt_in, outputs update on rising edge 2+STABLE_CYCLES, counting the first capturing edge as 1. With the default, that is the 4th edge.
- Glitch rule: a value held for fewer than STABLE_CYCLES synchronized samples is never accepted. A return to the already-accepted value generates no event.
- On acceptance, all outputs are registered in the same edge:
  - cnt_out<=cand and cnt_valid<=1.
  - delta = cand − cnt_out, mod 2^WIDTH.
- FSM states and transitions:
  - INIT: the first acceptance loads cnt_out and pulses cnt_valid only, with no classification. Next state TRACK.
  - TRACK, delta=1: step_up. If old=max and new=0, also wrap and wrap_count+1.
  - TRACK, delta=all-ones: step_dn. If old=0 and new=max, also wrap and wrap_count+1.
  - TRACK, direction check: dir_err pulses with the step when the step disagrees with up.
  - TRACK, any other nonzero delta: skip_err<=1, no step/wrap flags; next state ERROR.
  - ERROR: acceptances still update cnt_out and pulse cnt_valid. Steps, wraps and dir_err are suppressed and wrap_count is frozen.
- clr_err:
  - In ERROR: skip_err<=0 and state<=TRACK. In INIT and TRACK it has no effect.
  - If it coincides with an acceptance, cnt_out updates and cnt_valid pulses, but no classification occurs. A new skip in that cycle is ignored.
- Pulse outputs are high for exactly one cycle; back-to-back acceptances are not possible when STABLE_CYCLES≥2.
- Reset asserted mid-operation clears everything on that edge, including wrap_count and skip_err. Tracking restarts from INIT.

Decomposition:
- Package ripple_mon_pkg holds:
  - the state enum {INIT, TRACK, ERROR};
  - WIDTH_DEFAULT=4;
  - WRAP_CNT_W=8.
- One sub-module, sync_stable_filter: s1/s2, cand, run and the accept strobe, with output acc_val. The top level holds the FSM, the classifier and the counters.

Test Plan:
- Reset, then cnt_in=0 held: exactly one cnt_valid with cnt_out=0 within 4 edges. No step/wrap/err flags.
- up=1; cnt_in steps 0→1→…→15→0, each value held 4 cycles: 16 step_up pulses, 1 wrap at 15→0, wrap_count=1, no dir_err.
- up=0 from 0: cnt_in 0→15→14, each held 4 cycles: step_dn twice, wrap on 0→15, wrap_count=1.
- Ripple transient: settled 7. Drive 6 for 1 cycle, then 4 for 1 cycle, then 0 for 1 cycle, then hold 8. Expect a single acceptance, cnt_out=8, step_up=1, skip_err=0.
- Skip sequence:
  - Settled 2, then hold 5: skip_err=1, FSM in ERROR.
  - Then 6: cnt_valid pulses, step_up stays 0.
  - clr_err pulse: skip_err=0.
  - Then 7: step_up=1.
- Direction and reset:
  - up=1, settled 9, then hold 8: step_dn=1 and dir_err=1 for one cycle.
  - Then rst_n=0 for one edge while wrap_count=3: the next edge shows wrap_count=0, cnt_out=0, skip_err=0.
